// File: rtl/digital_mem_responder_if.sv
// rtl/digital_mem_responder_if.sv - digital_mem request/response port bundle
interface digital_mem_responder_if;
    logic [31:0] digital_mem_addr;
    logic        digital_mem_write_en;
    logic        digital_mem_read_en;
    logic [3:0]  digital_mem_byte_size;
    logic [31:0] digital_mem_wdata;
    logic [31:0] digital_mem_data;
    logic        digital_mem_ready;
    logic        digital_mem_err;

    modport master (
        output digital_mem_addr,
        output digital_mem_write_en,
        output digital_mem_read_en,
        output digital_mem_byte_size,
        output digital_mem_wdata,
        input  digital_mem_data,
        input  digital_mem_ready,
        input  digital_mem_err
    );

    modport slave (
        input  digital_mem_addr,
        input  digital_mem_write_en,
        input  digital_mem_read_en,
        input  digital_mem_byte_size,
        input  digital_mem_wdata,
        output digital_mem_data,
        output digital_mem_ready,
        output digital_mem_err
    );
endinterface

// File: rtl/digital_mem_responder.sv
// rtl/digital_mem_responder.sv - fixed-latency word RAM responder for the digital_mem port
// Defining DIGITAL_MEM_STALL_EN adds 0..3 edges of LFSR-driven extra latency per request.
module digital_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    digital_mem_responder_if.slave mem
);
    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
`ifdef DIGITAL_MEM_STALL_EN
    localparam int CNT_W = 5;
`else
    localparam int CNT_W = 4;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, RESP, REL} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_load;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       mask_q;
    logic             write_q;
    logic             err_q;
    logic [31:0]      data_q;
    logic [31:0]      ram [DEPTH_WORDS];

    logic             req;
    logic             access;
    logic             in_range;
    logic [32:0]      offset;
    logic [AW-1:0]    index;

    assign req    = mem.digital_mem_write_en | mem.digital_mem_read_en;
    assign access = (state == BUSY) && (cnt == '0);
    // Addresses below the base wrap to a huge 33-bit offset, so one compare covers both bounds.
    assign offset   = {1'b0, addr_q} - {1'b0, BASE_ADDR};
    assign in_range = (offset < SPAN);
    assign index    = offset[AW+1:2];

`ifdef DIGITAL_MEM_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign cnt_load = CNT_W'(LATENCY - 1) + CNT_W'(lfsr[1:0]);
`else
    assign cnt_load = CNT_W'(LATENCY - 1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req) state_nxt = BUSY;
            BUSY: if (cnt == '0) state_nxt = RESP;
            RESP: state_nxt = REL;
            REL:  if (!req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem.digital_mem_ready = (state == RESP);
        mem.digital_mem_err   = (state == RESP) && err_q;
        mem.digital_mem_data  = data_q;
    end

    // Request fields are captured only in IDLE, so bus activity during BUSY/RESP is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            if (state == IDLE && req) begin
                cnt     <= cnt_load;
                addr_q  <= mem.digital_mem_addr;
                wdata_q <= mem.digital_mem_wdata;
                mask_q  <= mem.digital_mem_byte_size;
                write_q <= mem.digital_mem_write_en;
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (access) begin
                err_q <= !in_range;
                if (!write_q) begin
                    data_q <= in_range ? ram[index] : 32'h0;
                end
            end
        end
    end

    // A reset forces IDLE, which drops access and so cancels any pending write.
    always_ff @(posedge clk) begin
        if (access && write_q && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (mask_q[i]) begin
                    ram[index][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_digital_mem_responder.sv
// tb/tb_digital_mem_responder.sv - randomized self-checking bench for digital_mem_responder
module tb_digital_mem_responder;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          LAT  = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    digital_mem_responder_if bus();

    digital_mem_responder #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (4096),
        .LATENCY     (LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mem   (bus.slave)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] model [int];
    logic [31:0] last_data;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic bit addr_in_range(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'h0000_4000);
    endfunction

    task automatic op(input bit w, input bit r, input logic [31:0] a,
                      input logic [3:0] m, input logic [31:0] wd);
        logic [31:0] exp_data;
        logic [31:0] tmp;
        bit          inr;
        int          k;
        int          n;
        inr = addr_in_range(a);
        k   = int'((a - BASE) >> 2);
        if (w) begin
            if (inr) begin
                tmp = model[k];
                for (int i = 0; i < 4; i++) if (m[i]) tmp[8*i +: 8] = wd[8*i +: 8];
                model[k] = tmp;
            end
            exp_data = last_data;
        end else begin
            exp_data = inr ? model[k] : 32'h0;
        end
        last_data = exp_data;

        bus.digital_mem_addr      = a;
        bus.digital_mem_byte_size = m;
        bus.digital_mem_wdata     = wd;
        bus.digital_mem_write_en  = w;
        bus.digital_mem_read_en   = r;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.digital_mem_ready && n < 20);
        check_val("latency", 32'(n - 1), 32'(LAT));
        check_val("err", 32'(bus.digital_mem_err), 32'(!inr));
        check_val("data", bus.digital_mem_data, exp_data);
        bus.digital_mem_write_en = 1'b0;
        bus.digital_mem_read_en  = 1'b0;
        @(negedge clk);
        check_val("ready_pulse", 32'(bus.digital_mem_ready), 32'h0);
        @(negedge clk);
    endtask

    initial begin
        int          n;
        int          cnt;
        int          k;
        int          t;
        logic [31:0] a;

        rst_n = 1'b0;
        bus.digital_mem_addr      = '0;
        bus.digital_mem_write_en  = 1'b0;
        bus.digital_mem_read_en   = 1'b0;
        bus.digital_mem_byte_size = '0;
        bus.digital_mem_wdata     = '0;
        last_data = 32'h0;
        repeat (3) @(negedge clk);
        check_val("rst_data", bus.digital_mem_data, 32'h0);
        check_val("rst_ready", 32'(bus.digital_mem_ready), 32'h0);
        check_val("rst_err", 32'(bus.digital_mem_err), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) op(1'b1, 1'b0, BASE + 32'(4 * i), 4'hF, $urandom);
        op(1'b1, 1'b0, BASE + 32'h3FFC, 4'hF, $urandom);
        op(1'b0, 1'b1, BASE + 32'h3FFC, 4'h0, 32'h0);

        op(1'b1, 1'b0, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF);
        op(1'b0, 1'b1, 32'h8000_0010, 4'hF, 32'h0);
        check_val("deadbeef", bus.digital_mem_data, 32'hDEAD_BEEF);
        op(1'b1, 1'b0, 32'h8000_0010, 4'b0101, 32'h1122_3344);
        op(1'b0, 1'b1, 32'h8000_0010, 4'h0, 32'h0);
        check_val("lane_mix", bus.digital_mem_data, 32'hDE22_BE44);
        op(1'b1, 1'b0, 32'h8000_0014, 4'h0, 32'hFFFF_FFFF);

        op(1'b0, 1'b1, 32'h8000_4000, 4'hF, 32'h0);
        check_val("oor_zero", bus.digital_mem_data, 32'h0);
        op(1'b1, 1'b0, 32'h8000_4000, 4'hF, 32'hFFFF_FFFF);
        op(1'b1, 1'b0, 32'h7FFF_FFFC, 4'hF, 32'hFFFF_FFFF);

        op(1'b0, 1'b1, 32'h8000_0010, 4'hF, 32'h0);
        op(1'b1, 1'b1, 32'h8000_0018, 4'hF, 32'h5A5A_5A5A);
        check_val("both_keep", bus.digital_mem_data, 32'hDE22_BE44);
        op(1'b0, 1'b1, 32'h8000_0018, 4'hF, 32'h0);
        check_val("both_read", bus.digital_mem_data, 32'h5A5A_5A5A);

        bus.digital_mem_addr    = BASE + 32'h14;
        bus.digital_mem_read_en = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.digital_mem_ready && n < 20);
        check_val("hold_lat", 32'(n - 1), 32'(LAT));
        check_val("hold_data", bus.digital_mem_data, model[5]);
        last_data = model[5];
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.digital_mem_ready) cnt++;
        end
        check_val("hold_once", 32'(cnt), 32'h0);
        bus.digital_mem_read_en = 1'b0;
        @(negedge clk);
        op(1'b0, 1'b1, BASE + 32'h18, 4'h0, 32'h0);

        op(1'b1, 1'b0, 32'h8000_0020, 4'hF, 32'h0123_4567);
        op(1'b0, 1'b1, 32'h8000_0010, 4'hF, 32'h0);
        bus.digital_mem_addr      = 32'h8000_0020;
        bus.digital_mem_wdata     = 32'hFFFF_FFFF;
        bus.digital_mem_byte_size = 4'hF;
        bus.digital_mem_write_en  = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        bus.digital_mem_write_en = 1'b0;
        #1;
        check_val("abort_data", bus.digital_mem_data, 32'h0);
        check_val("abort_ready", 32'(bus.digital_mem_ready), 32'h0);
        check_val("abort_err", 32'(bus.digital_mem_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        last_data = 32'h0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.digital_mem_ready) cnt++;
        end
        check_val("abort_noready", 32'(cnt), 32'h0);
        op(1'b0, 1'b1, 32'h8000_0020, 4'hF, 32'h0);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 2))
                    0:       a = BASE - 32'(4 * $urandom_range(1, 64));
                    1:       a = BASE + 32'h4000 + 32'(4 * $urandom_range(0, 64));
                    default: a = $urandom & 32'h7FFF_FFFF;
                endcase
            end else begin
                k = $urandom_range(0, 16);
                if (k == 16) k = 4095;
                a = BASE + 32'(4 * k);
            end
            a[1:0] = 2'($urandom);
            t = $urandom_range(0, 3);
            op(t >= 2, t != 2, a, 4'($urandom), $urandom);
        end

        foreach (model[idx]) op(1'b0, 1'b1, BASE + 32'(4 * idx), 4'h0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
